cim: RTL and testbench
======================

Name: cim

Overview:
- Compute-in-memory MAC core: holds a 32-element vector of 4-bit unsigned weights and, for each 32-element 4-bit unsigned input feature vector, produces the 13-bit unsigned dot product.
- Accepts one input vector per clock, fully pipelined, and sits as the leaf compute engine behind the feature-map streaming logic.

Parameters:
- N, 32, number of weight/IFM elements per vector.
- DW, 4, bit width of each weight and each IFM element (unsigned).
- OW, 13, output width; 32*15*15 = 7200 < 8192, so there is no overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  In_IFM holds a valid vector this cycle.
- weight_valid  input  1  In_Weight holds a valid vector this cycle; load the weight register.
- In_IFM  input  128  32 x 4-bit unsigned. Element 1 is in bits [127:124], element 32 in bits [3:0].
- In_Weight  input  128  32 x 4-bit unsigned, same packing as In_IFM.
- out_valid  output  1  Out_OFM is valid this cycle.
- Out_OFM  output  13  unsigned dot product sum(W[k]*IFM[k]), k = 1..32.

Behaviour:
- Reset: at a rising edge with rst_n = 0, clear the following to 0:
  - weight register (all 32 elements)
  - all pipeline registers and stage valids
  - out_valid and Out_OFM
- Weight load: at a rising edge with weight_valid = 1, the weight register captures In_Weight. Otherwise it holds its value; weights persist indefinitely.
- Compute pipeline: 2-stage, fixed latency 2.
  - Stage 1 (edge k, in_valid = 1): register 32 products. Each product is 8 bits, IFM[k] x Wreg[k], using the weight register value *before* this edge. Set stage-1 valid.
  - Stage 2 (edge k+1): add-tree sum of the 32 products into the Out_OFM register, zero-extended to 13 bits. out_valid = stage-1 valid.
  - Result: out_valid = 1 and Out_OFM is correct during the cycle after edge k+1.
- Throughput: one vector per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles, in order.
- Idle output: when out_valid = 0, Out_OFM is driven to 0, not held.
- Simultaneous weight_valid and in_valid on the same edge: the vector uses the old weights. The new weights apply from the next edge.
- in_valid before any weight load: computes with the reset weights, so Out_OFM = 0 with out_valid = 1.
- Reset mid-stream: all in-flight results are discarded. out_valid = 0 from the first edge with rst_n = 0. Weights are cleared.
- Arithmetic: all unsigned. The adder tree uses widths growing to 13 bits, with no truncation below 13 bits.
- No X propagation: when in_valid = 0, IFM contents are don't-care but must not affect outputs.

Decomposition:
- Shared package cim_pkg:
  - constants N, DW, OW
  - derived PW = 2*DW = 8 (product width)
  - packed-vector width N*DW = 128
- Optional sub-module cim_adder_tree: combinational sum of N PW-bit unsigned values into OW bits. Instantiated once, between the product register and the output register.
- Top holds:
  - weight register
  - 32 multipliers
  - stage registers
  - valid shift chain

Test Plan:
- Reset then idle:
  - rst_n low for 1 edge -> out_valid = 0, Out_OFM = 0.
  - in_valid = 0 for 10 cycles -> out_valid stays 0.
- Maximum value: load all weights = 15, one vector all IFM = 15 -> exactly 2 cycles later out_valid = 1, Out_OFM = 7200. Next cycle out_valid = 0, Out_OFM = 0.
- Element ordering: weights = 0 except element 1 = 1 (bits [127:124] = 4'h1). Apply IFM element 1 = 9 and element 32 = 7 -> Out_OFM = 9. Then load weight element 32 only = 2 -> Out_OFM = 14.
- Streaming 50 vectors:
  - Load random weights once.
  - Apply 50 random IFM vectors on consecutive cycles.
  - Expect 50 consecutive out_valid pulses starting 2 cycles after the first, each matching a software dot product in order.
- Weight-update ordering:
  - Weights all 1, then weight_valid = 1 with all 2 on the same edge as in_valid = 1 with IFM all 1 -> Out_OFM = 32.
  - Following vector with IFM all 1 -> 64.
- Reset mid-stream:
  - Assert rst_n = 0 for 1 cycle while vectors are in flight -> no out_valid for the pre-reset vectors.
  - A subsequent vector without a weight reload -> Out_OFM = 0, out_valid = 1.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared constants for the compute-in-memory MAC core: vector length,
// element width, product width and result width.
package cim_pkg;
  localparam int N  = 32;
  localparam int DW = 4;
  localparam int OW = 13;
  localparam int PW = 2 * DW;
  localparam int VW = N * DW;
endpackage

// File: rtl/cim_adder_tree.sv
// Combinational binary adder tree summing N unsigned PW-bit products.
// Each level widens by one bit, so the root is exactly OW bits wide.
module cim_adder_tree
  import cim_pkg::*;
(
  input  logic [N*PW-1:0] prod,
  output logic [OW-1:0]   sum
);
  localparam int LVL = $clog2(N);

  genvar l, i;
  for (l = 0; l <= LVL; l++) begin : g_lvl
    logic [PW+l-1:0] node [N>>l];
    if (l == 0) begin : g_leaf
      for (i = 0; i < N; i++) begin : g_in
        assign node[i] = prod[i*PW +: PW];
      end
    end else begin : g_add
      for (i = 0; i < (N >> l); i++) begin : g_pair
        assign node[i] = {1'b0, g_lvl[l-1].node[2*i]} + {1'b0, g_lvl[l-1].node[2*i+1]};
      end
    end
  end

  assign sum = OW'(g_lvl[LVL].node[0]);
endmodule

// File: rtl/cim.sv
// MAC core: stored weight vector times incoming IFM vector, one vector per
// clock, two-cycle latency; output forced to zero whenever it is not valid.
module cim
  import cim_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          weight_valid,
  input  logic [VW-1:0] In_IFM,
  input  logic [VW-1:0] In_Weight,
  output logic          out_valid,
  output logic [OW-1:0] Out_OFM
);
  logic [VW-1:0]   weight_reg;
  logic [N*PW-1:0] prod_p0;
  logic [N*PW-1:0] prod_p1;
  logic            vld_p1;
  logic [OW-1:0]   sum_p1;

  // Stage 0: element-wise products against the currently held weights
  always_comb begin
    prod_p0 = '0;
    for (int k = 0; k < N; k++) begin
      prod_p0[k*PW +: PW] = PW'(In_IFM[k*DW +: DW]) * PW'(weight_reg[k*DW +: DW]);
    end
  end

  // Stage 1: product register; holds when idle so stray IFM bits never reach it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_reg <= '0;
      prod_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      if (weight_valid) weight_reg <= In_Weight;
      if (in_valid)     prod_p1    <= prod_p0;
      vld_p1 <= in_valid;
    end
  end

  cim_adder_tree u_tree (
    .prod (prod_p1),
    .sum  (sum_p1)
  );

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out_OFM   <= '0;
    end else begin
      out_valid <= vld_p1;
      Out_OFM   <= vld_p1 ? sum_p1 : '0;
    end
  end
endmodule

// File: tb/tb_cim.sv
// Bench for cim: directed vector table, streaming and randomized traffic
// checked against a queue-based dot-product model.
module tb_cim;
  import cim_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          weight_valid = 1'b0;
  logic [127:0]  In_IFM = '0;
  logic [127:0]  In_Weight = '0;
  logic          out_valid;
  logic [12:0]   Out_OFM;

  always #5 clk = ~clk;

  cim dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .In_IFM       (In_IFM),
    .In_Weight    (In_Weight),
    .out_valid    (out_valid),
    .Out_OFM      (Out_OFM)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: weights as integers, results queued with -1 meaning "no result"
  int mw [1:32];
  int mq [$];
  bit model_on = 1'b0;
  int exp_now  = -1;

  typedef struct {
    logic         rstn;
    logic         wv;
    logic [127:0] w;
    logic         inv;
    logic [127:0] ifm;
    logic         ev;
    logic [12:0]  eo;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic rstn, input logic wv, input logic [127:0] w,
                              input logic inv, input logic [127:0] ifm,
                              input logic ev, input logic [12:0] eo);
    vec_t v;
    v.rstn = rstn; v.wv = wv; v.w = w; v.inv = inv; v.ifm = ifm; v.ev = ev; v.eo = eo;
    return v;
  endfunction

  function automatic int dot(input logic [127:0] ifm);
    int s = 0;
    for (int k = 1; k <= 32; k++) s += int'(ifm[128-4*k +: 4]) * mw[k];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic wv, input logic [127:0] w,
                      input logic inv, input logic [127:0] ifm);
    rst_n = rstn; weight_valid = wv; In_Weight = w; in_valid = inv; In_IFM = ifm;
    @(posedge clk);
    if (!rstn) begin
      mq = {-1};
      for (int k = 1; k <= 32; k++) mw[k] = 0;
      exp_now  = -1;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_now = mq.pop_front();
      mq.push_back(inv ? dot(ifm) : -1);
      if (wv) for (int k = 1; k <= 32; k++) mw[k] = int'(w[128-4*k +: 4]);
    end
    #1;
    if (model_on) begin
      check("model_vld", int'(out_valid), (exp_now >= 0) ? 1 : 0);
      check("model_ofm", int'(Out_OFM), (exp_now >= 0) ? exp_now : 0);
    end
  endtask

  initial begin
    logic [127:0] a15, a1, a2, e1w, ifm_o, w32;
    int pulses, first_idx, last_idx;
    a15   = {32{4'hF}};
    a1    = {32{4'h1}};
    a2    = {32{4'h2}};
    e1w   = {4'h1, 124'h0};
    ifm_o = {4'h9, 120'h0, 4'h7};
    w32   = 128'h2;

    // Reset then idle
    step(1'b0, 1'b0, '0, 1'b0, rnd128());
    check("rst_vld", int'(out_valid), 0);
    check("rst_ofm", int'(Out_OFM), 0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, '0, 1'b0, rnd128());
      check("idle_vld", int'(out_valid), 0);
    end

    tbl[0]  = mk(1'b0, 1'b0, '0,    1'b0, '0,    1'b0, 13'd0);
    tbl[1]  = mk(1'b1, 1'b1, a15,   1'b0, '0,    1'b0, 13'd0);
    tbl[2]  = mk(1'b1, 1'b0, '0,    1'b1, a15,   1'b0, 13'd0);
    tbl[3]  = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b1, 13'd7200);
    tbl[4]  = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b0, 13'd0);
    tbl[5]  = mk(1'b1, 1'b1, e1w,   1'b0, '0,    1'b0, 13'd0);
    tbl[6]  = mk(1'b1, 1'b0, '0,    1'b1, ifm_o, 1'b0, 13'd0);
    tbl[7]  = mk(1'b1, 1'b1, w32,   1'b0, '0,    1'b1, 13'd9);
    tbl[8]  = mk(1'b1, 1'b0, '0,    1'b1, ifm_o, 1'b0, 13'd0);
    tbl[9]  = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b1, 13'd14);
    tbl[10] = mk(1'b1, 1'b1, a1,    1'b0, '0,    1'b0, 13'd0);
    tbl[11] = mk(1'b1, 1'b1, a2,    1'b1, a1,    1'b0, 13'd0);
    tbl[12] = mk(1'b1, 1'b0, '0,    1'b1, a1,    1'b1, 13'd32);
    tbl[13] = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b1, 13'd64);
    tbl[14] = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b0, 13'd0);
    tbl[15] = mk(1'b1, 1'b0, '0,    1'b1, a15,   1'b0, 13'd0);
    tbl[16] = mk(1'b1, 1'b0, '0,    1'b1, a15,   1'b1, 13'd960);
    tbl[17] = mk(1'b0, 1'b0, '0,    1'b1, a15,   1'b0, 13'd0);
    tbl[18] = mk(1'b1, 1'b0, '0,    1'b1, a15,   1'b0, 13'd0);
    tbl[19] = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b1, 13'd0);
    tbl[20] = mk(1'b1, 1'b0, '0,    1'b0, '0,    1'b0, 13'd0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rstn, tbl[i].wv, tbl[i].wv ? tbl[i].w : rnd128(),
           tbl[i].inv, tbl[i].inv ? tbl[i].ifm : rnd128());
      check($sformatf("tbl_vld[%0d]", i), int'(out_valid), int'(tbl[i].ev));
      check($sformatf("tbl_ofm[%0d]", i), int'(Out_OFM), int'(tbl[i].eo));
    end

    // Streaming: one weight load, 50 back-to-back vectors, then drain
    pulses = 0; first_idx = -1; last_idx = -1;
    for (int s = 0; s < 54; s++) begin
      if (s == 0)      step(1'b1, 1'b1, rnd128(), 1'b0, rnd128());
      else if (s <= 50) step(1'b1, 1'b0, rnd128(), 1'b1, rnd128());
      else             step(1'b1, 1'b0, rnd128(), 1'b0, rnd128());
      if (out_valid) begin
        pulses++;
        if (first_idx < 0) first_idx = s;
        last_idx = s;
      end
    end
    check("stream_pulses", pulses, 50);
    check("stream_first", first_idx, 2);
    check("stream_contig", last_idx - first_idx + 1, 50);

    // Randomized mix of weight loads, vectors, idles and occasional resets
    for (int s = 0; s < 400; s++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0), rnd128(),
           ($urandom_range(0, 2) != 0), rnd128());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
